// File: rtl/branch_history_table_pkg.sv
// rtl/branch_history_table_pkg.sv - shared branch-prediction constants
// Purpose: 2-bit counter encodings, counter reset value and default PC/index
//          widths shared by the direction predictor, the BTB and fetch.
// Ports:   none (package).
package branch_history_table_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT   = 2'b00;
   localparam ctr_t CTR_WNT   = 2'b01;
   localparam ctr_t CTR_WT    = 2'b10;
   localparam ctr_t CTR_ST    = 2'b11;
   localparam ctr_t CTR_RESET = CTR_WNT;

   localparam int BHT_BRANCH_PC   = 10;
   localparam int BHT_INDEX_WIDTH = 6;
   localparam int BHT_HIST_WIDTH  = 6;

endpackage

// File: rtl/branch_history_table_if.sv
// rtl/branch_history_table_if.sv - lookup/prediction/update bundle of the direction predictor
// Purpose: groups the fetch lookup, registered prediction and execute update signals.
// Ports:   master = fetch/execute side (drives lookup_* and update_*, receives pred_*)
//          slave  = predictor side (receives lookup_* and update_*, drives pred_*)
interface branch_history_table_if
   import branch_history_table_pkg::*;
#(
   parameter int BRANCH_PC   = BHT_BRANCH_PC,
   parameter int INDEX_WIDTH = BHT_INDEX_WIDTH
) ();

   logic                   lookup_valid;
   logic [BRANCH_PC-1:0]   lookup_pc;
   logic                   pred_valid;
   logic                   pred_taken;
   logic [1:0]             pred_counter;
   logic [INDEX_WIDTH-1:0] pred_index;
   logic                   update_valid;
   logic [INDEX_WIDTH-1:0] update_index;
   logic                   update_taken;

   modport master (
      output lookup_valid, lookup_pc, update_valid, update_index, update_taken,
      input  pred_valid, pred_taken, pred_counter, pred_index
   );

   modport slave (
      input  lookup_valid, lookup_pc, update_valid, update_index, update_taken,
      output pred_valid, pred_taken, pred_counter, pred_index
   );

endinterface

// File: rtl/branch_history_table_sat_counter.sv
// rtl/branch_history_table_sat_counter.sv - 2-bit saturating counter next-state logic
// Purpose: combinational next value of a 2-bit direction counter.
// Ports:   i_cur   current counter value
//          i_taken resolved outcome (1 = count up, 0 = count down)
//          o_nxt   saturated next value
module sat_counter_2b
   import branch_history_table_pkg::*;
(
   input  logic [1:0] i_cur,
   input  logic       i_taken,
   output logic [1:0] o_nxt
);

   always_comb begin
      o_nxt = i_cur;
      if (i_taken) begin
         if (i_cur != CTR_ST) o_nxt = i_cur + 2'd1;
      end else begin
         if (i_cur != CTR_SNT) o_nxt = i_cur - 2'd1;
      end
   end

endmodule

// File: rtl/branch_history_table.sv
// rtl/branch_history_table.sv - gshare direction predictor beside the BTB
// Purpose: table of 2-bit counters indexed by PC[INDEX_WIDTH+1:2] XOR GHR.
//          Lookup latency is one cycle; the GHR advances only on resolved updates.
// Ports:   i_clk  core clock, all state on the rising edge
//          i_rst  synchronous active-high reset
//          bht    slave modport: lookup_*, update_* in; registered pred_* out
module branch_history_table
   import branch_history_table_pkg::*;
#(
   parameter int BRANCH_PC   = BHT_BRANCH_PC,
   parameter int INDEX_WIDTH = BHT_INDEX_WIDTH,
   parameter int HIST_WIDTH  = BHT_HIST_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   branch_history_table_if.slave bht
);

   localparam int DEPTH = 1 << INDEX_WIDTH;

   logic [1:0]             r_ctr [DEPTH];
   logic [HIST_WIDTH-1:0]  r_ghr;
   logic                   r_pred_valid;
   logic                   r_pred_taken;
   logic [1:0]             r_pred_counter;
   logic [INDEX_WIDTH-1:0] r_pred_index;

   logic [INDEX_WIDTH-1:0] w_idx;
   logic [1:0]             w_upd_nxt;
   logic [1:0]             w_lookup_ctr;
   logic [HIST_WIDTH:0]    w_ghr_cat;
   logic [HIST_WIDTH-1:0]  w_ghr_nxt;
   logic                   w_unused_pc;

   // Low PC bits select a byte within the word and the high bits fall outside
   // the table index, so they are intentionally not part of the hash.
   assign w_unused_pc = ^bht.lookup_pc;

   // Lookup hashes with the GHR as it stands before any same-cycle update.
   assign w_idx = bht.lookup_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(r_ghr);

   sat_counter_2b u_sat (
      .i_cur   (r_ctr[bht.update_index]),
      .i_taken (bht.update_taken),
      .o_nxt   (w_upd_nxt)
   );

   // Write-first bypass: a lookup hitting the entry being updated sees the new value.
   assign w_lookup_ctr = (bht.update_valid && (bht.update_index == w_idx))
                         ? w_upd_nxt : r_ctr[w_idx];

   // Shift-in of the outcome; taking the low bits of the concatenation also
   // covers a one-bit history.
   assign w_ghr_cat = {r_ghr, bht.update_taken};
   assign w_ghr_nxt = w_ghr_cat[HIST_WIDTH-1:0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_ctr[i] <= CTR_RESET;
         r_ghr          <= '0;
         r_pred_valid   <= 1'b0;
         r_pred_taken   <= 1'b0;
         r_pred_counter <= CTR_RESET;
         r_pred_index   <= '0;
      end else begin
         if (bht.update_valid) begin
            r_ctr[bht.update_index] <= w_upd_nxt;
            r_ghr                   <= w_ghr_nxt;
         end
         r_pred_valid <= bht.lookup_valid;
         if (bht.lookup_valid) begin
            r_pred_taken   <= w_lookup_ctr[1];
            r_pred_counter <= w_lookup_ctr;
            r_pred_index   <= w_idx;
         end
      end
   end

   assign bht.pred_valid   = r_pred_valid;
   assign bht.pred_taken   = r_pred_taken;
   assign bht.pred_counter = r_pred_counter;
   assign bht.pred_index   = r_pred_index;

endmodule

// File: doc/branch_history_table.md
Name: branch_history_table

Overview:
- Direction predictor that sits beside the BTB in the fetch stage. The BTB supplies the target; this block decides taken / not-taken.
- Gshare organisation: a table of 2-bit saturating counters, indexed by the word-aligned PC XOR a global history register (GHR).
- Lookups come from fetch. Updates come from branch resolution in execute, and the GHR is updated only at resolution (non-speculative).

Parameters:
- BRANCH_PC, 10, width of the PC slice presented by fetch (same slice the BTB uses).
- INDEX_WIDTH, 6, log2 of table depth (64 counters); requires BRANCH_PC >= INDEX_WIDTH+2.
- HIST_WIDTH, 6, GHR length; requires 1 <= HIST_WIDTH <= INDEX_WIDTH.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- lookup_valid  in  1  fetch requests a prediction this cycle.
- lookup_pc  in  BRANCH_PC  PC slice of the fetched instruction.
- pred_valid  out  1  registered; high the cycle after an accepted lookup.
- pred_taken  out  1  registered; MSB of the selected counter.
- pred_counter  out  2  registered; full counter value, for debug and confidence.
- pred_index  out  INDEX_WIDTH  registered; index used, carried down the pipe for update.
- update_valid  in  1  a conditional branch resolved this cycle.
- update_index  in  INDEX_WIDTH  pred_index returned from execute.
- update_taken  in  1  actual branch outcome.

Behaviour:
- Reset (rst=1 at an edge):
  - all counters <= 2'b01 (weakly not-taken); GHR <= 0.
  - pred_valid, pred_taken <= 0; pred_counter <= 2'b01; pred_index <= 0.
  - Lookups and updates presented in the same cycle as rst are dropped.
  - Reset asserted mid-stream discards any in-flight prediction.
- Index: idx = lookup_pc[INDEX_WIDTH+1:2] XOR zero-extend(GHR). PC bits [1:0] are ignored.
- Lookup, latency 1:
  - When lookup_valid=1 in cycle N, pred_* reflect idx in cycle N+1 and pred_valid=1.
  - When lookup_valid=0, pred_valid <= 0 and the other pred_* outputs hold their previous values.
- Counter update on update_valid=1:
  - taken: 00->01->10->11, saturating at 11.
  - not-taken: 11->10->01->00, saturating at 00.
  - Exactly one entry changes per cycle.
- GHR on update_valid=1: GHR <= {GHR[HIST_WIDTH-2:0], update_taken}. For HIST_WIDTH=1, GHR <= update_taken. GHR is unchanged otherwise.
- Simultaneous lookup and update in the same cycle:
  - The lookup index uses the GHR value before the update.
  - If update_index == idx, the prediction uses the post-update counter (write-first bypass).
  - Different indices do not interact.
- No backpressure. Lookups are accepted every cycle; the consumer must register pred_* if it stalls.
- Storage is flops; there is no SRAM read-latency assumption.

Decomposition:
- Shared package (branch_pkg), reused by the BTB and fetch:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11, and reset value WNT.
  - default widths BRANCH_PC=10, INDEX_WIDTH=6.
- One combinational sub-module, sat_counter_2b: inputs cur[1:0] and taken; output nxt[1:0].
  - Used for both the table write and the bypass path.

Test Plan:
- Reset, then lookup_pc=0x010 -> cycle N+1: pred_valid=1, pred_index=4, pred_counter=01, pred_taken=0.
- Two updates, idx 4, taken=1 -> counter[4]=11 and GHR=000011. Then lookup_pc=0x010 -> pred_index=4^3=7, pred_counter=01. Lookup_pc=0x01C -> index 7^3=4, pred_taken=1.
- Saturation:
  - five taken updates on idx 9 -> counter 11, and a further taken update leaves it at 11.
  - four not-taken updates -> 00, and a further not-taken update stays 00.
- Same-cycle bypass: counter[5]=01, GHR=0; lookup_pc=0x014 together with update idx 5 taken -> pred_counter=10, pred_taken=1, pred_index=5 (pre-update GHR).
- Mid-stream reset: after training idx 4 to 11, assert rst for 1 cycle together with a lookup -> next cycle pred_valid=0. A subsequent lookup of 0x010 returns counter 01 with GHR 0.
- lookup_valid=0 for 3 cycles after a prediction -> pred_valid=0 and pred_index holds its last value. GHR changes only on cycles with update_valid=1.
